// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode CSR unit: addresses, field positions,
// cause codes and the read/modify/write helper.
package csr_pkg;

    localparam logic [11:0] ADDR_MSTATUS = 12'h300;
    localparam logic [11:0] ADDR_MIE     = 12'h304;
    localparam logic [11:0] ADDR_MTVEC   = 12'h305;
    localparam logic [11:0] ADDR_MEPC    = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
    localparam logic [11:0] ADDR_MIP     = 12'h344;

    localparam int MIE_BIT  = 3;
    localparam int MPIE_BIT = 7;
    localparam int MTI_BIT  = 7;
    localparam int MEI_BIT  = 11;

    localparam logic [4:0] CAUSE_MTI = 5'd7;
    localparam logic [4:0] CAUSE_MEI = 5'd11;

    localparam logic [31:0] MSTATUS_MASK = 32'h0000_0088;
    localparam logic [31:0] MIE_MASK     = 32'h0000_0880;

    typedef enum logic [1:0] {
        CSR_NONE = 2'b00,
        CSR_RW   = 2'b01,
        CSR_RS   = 2'b10,
        CSR_RC   = 2'b11
    } csr_op_e;

    function automatic logic [31:0] csr_modify(input csr_op_e op,
                                               input logic [31:0] old_v,
                                               input logic [31:0] wd);
        logic [31:0] res;
        case (op)
            CSR_RW:  res = wd;
            CSR_RS:  res = old_v | wd;
            CSR_RC:  res = old_v & ~wd;
            default: res = old_v;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/csr_file_irq_sync.sv
// Multi-flop synchronizer bringing an asynchronous level interrupt into the clk domain.
module irq_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_irq,
    output logic o_irq
);

    logic [SYNC_STAGES-1:0] r_sync;

    // shift the raw level through the synchronizer chain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_irq};
        end
    end

    assign o_irq = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/csr_file.sv
// Machine-mode CSR file: CSR read/modify/write, timer/external interrupt entry,
// mret, and the PC redirect back to fetch.
module csr_file
    import csr_pkg::*;
#(
    parameter logic [31:0] RESET_MTVEC = 32'h0000_0000,
    parameter int          SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        csr_reg_wr,
    input  logic        csr_reg_rd,
    input  logic        is_mret,
    input  logic [1:0]  csr_op,
    input  logic [11:0] addr,
    input  logic [31:0] wdata,
    input  logic [31:0] pc_in,
    input  logic        timer_irq,
    input  logic        ext_irq,
    output logic [31:0] rdata,
    output logic        epc_taken,
    output logic [31:0] epc
);

    logic [31:0] r_mstatus, r_mie, r_mtvec, r_mepc, r_mcause;
    logic [31:0] w_mstatus_nxt, w_mie_nxt, w_mtvec_nxt, w_mepc_nxt, w_mcause_nxt;
    logic        w_timer_s, w_ext_s;
    logic [31:0] w_mip, w_rd_val, w_new, w_irq_act, w_base, w_vec;
    logic        w_wr_en, w_pend, w_take;
    logic [4:0]  w_cause;

    irq_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_timer (
        .clk(clk), .rst_n(reset), .i_irq(timer_irq), .o_irq(w_timer_s)
    );
    irq_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ext (
        .clk(clk), .rst_n(reset), .i_irq(ext_irq), .o_irq(w_ext_s)
    );

    // mip view, pre-write read mux, pending/priority and trap target
    always_comb begin
        w_mip          = 32'h0000_0000;
        w_mip[MTI_BIT] = w_timer_s;
        w_mip[MEI_BIT] = w_ext_s;
        case (addr)
            ADDR_MSTATUS: w_rd_val = r_mstatus;
            ADDR_MIE:     w_rd_val = r_mie;
            ADDR_MTVEC:   w_rd_val = r_mtvec;
            ADDR_MEPC:    w_rd_val = r_mepc;
            ADDR_MCAUSE:  w_rd_val = r_mcause;
            ADDR_MIP:     w_rd_val = w_mip;
            default:      w_rd_val = 32'h0000_0000;
        endcase
        w_wr_en   = csr_reg_wr && (csr_op != 2'b00);
        w_new     = csr_modify(csr_op_e'(csr_op), w_rd_val, wdata);
        w_irq_act = r_mie & w_mip;
        w_pend    = r_mstatus[MIE_BIT] && (w_irq_act != 32'h0000_0000);
        // CSR writes and mret push the interrupt out so their own side effects land first
        w_take    = w_pend && !is_mret && !csr_reg_wr;
        w_cause   = w_irq_act[MEI_BIT] ? CAUSE_MEI : CAUSE_MTI;
        w_base    = {r_mtvec[31:2], 2'b00};
        w_vec     = w_base + {25'd0, w_cause, 2'b00};
    end

    // combinational outputs, forced quiet while reset is held
    always_comb begin
        rdata     = 32'h0000_0000;
        epc_taken = 1'b0;
        epc       = 32'h0000_0000;
        if (reset) begin
            rdata = csr_reg_rd ? w_rd_val : 32'h0000_0000;
            if (w_take) begin
                epc_taken = 1'b1;
                epc       = r_mtvec[0] ? w_vec : w_base;
            end else if (is_mret) begin
                epc_taken = 1'b1;
                epc       = r_mepc;
            end else begin
                epc_taken = 1'b0;
            end
        end else begin
            rdata = 32'h0000_0000;
        end
    end

    // next CSR state: software write, then trap entry, then mret (mret owns MIE/MPIE)
    always_comb begin
        w_mstatus_nxt = r_mstatus;
        w_mie_nxt     = r_mie;
        w_mtvec_nxt   = r_mtvec;
        w_mepc_nxt    = r_mepc;
        w_mcause_nxt  = r_mcause;
        if (w_wr_en) begin
            case (addr)
                ADDR_MSTATUS: w_mstatus_nxt = w_new & MSTATUS_MASK;
                ADDR_MIE:     w_mie_nxt     = w_new & MIE_MASK;
                ADDR_MTVEC:   w_mtvec_nxt   = w_new & 32'hFFFF_FFFD;
                ADDR_MEPC:    w_mepc_nxt    = w_new & 32'hFFFF_FFFC;
                ADDR_MCAUSE:  w_mcause_nxt  = w_new;
                default:      w_mcause_nxt  = r_mcause;
            endcase
        end else begin
            w_mcause_nxt = r_mcause;
        end
        if (w_take) begin
            w_mepc_nxt              = {pc_in[31:2], 2'b00};
            w_mcause_nxt            = {1'b1, 26'd0, w_cause};
            w_mstatus_nxt           = 32'h0000_0000;
            w_mstatus_nxt[MPIE_BIT] = r_mstatus[MIE_BIT];
        end else if (is_mret) begin
            w_mstatus_nxt           = 32'h0000_0000;
            w_mstatus_nxt[MIE_BIT]  = r_mstatus[MPIE_BIT];
            w_mstatus_nxt[MPIE_BIT] = 1'b1;
        end else begin
            w_mepc_nxt = w_mepc_nxt;
        end
    end

    // CSR state registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mstatus <= 32'h0000_0000;
            r_mie     <= 32'h0000_0000;
            r_mtvec   <= RESET_MTVEC;
            r_mepc    <= 32'h0000_0000;
            r_mcause  <= 32'h0000_0000;
        end else begin
            r_mstatus <= w_mstatus_nxt;
            r_mie     <= w_mie_nxt;
            r_mtvec   <= w_mtvec_nxt;
            r_mepc    <= w_mepc_nxt;
            r_mcause  <= w_mcause_nxt;
        end
    end

endmodule

// File: tb/tb_csr_file.sv
// Self-checking bench for csr_file: directed scenarios plus randomized traffic
// compared against a behavioural CSR model.
module tb_csr_file;

    localparam int          SYNC      = 2;
    localparam logic [31:0] RST_MTVEC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        csr_reg_wr, csr_reg_rd, is_mret;
    logic [1:0]  csr_op;
    logic [11:0] addr;
    logic [31:0] wdata, pc_in;
    logic        timer_irq, ext_irq;
    logic [31:0] rdata, epc;
    logic        epc_taken;

    always #5 clk = ~clk;

    csr_file #(.RESET_MTVEC(RST_MTVEC), .SYNC_STAGES(SYNC)) dut (
        .clk(clk), .reset(reset), .csr_reg_wr(csr_reg_wr), .csr_reg_rd(csr_reg_rd),
        .is_mret(is_mret), .csr_op(csr_op), .addr(addr), .wdata(wdata), .pc_in(pc_in),
        .timer_irq(timer_irq), .ext_irq(ext_irq), .rdata(rdata),
        .epc_taken(epc_taken), .epc(epc)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] m_mstatus, m_mie, m_mtvec, m_mepc, m_mcause;
    logic        t_hist[$];
    logic        e_hist[$];
    logic        irq_t = 1'b0;
    logic        irq_e = 1'b0;
    logic [31:0] obs_rdata, obs_epc;
    logic        obs_taken;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_mstatus = 32'h0;
        m_mie     = 32'h0;
        m_mtvec   = RST_MTVEC;
        m_mepc    = 32'h0;
        m_mcause  = 32'h0;
        t_hist.delete();
        e_hist.delete();
        for (int i = 0; i < SYNC; i++) begin
            t_hist.push_back(1'b0);
            e_hist.push_back(1'b0);
        end
    endtask

    // interrupt lines as seen SYNC-1 edges after they were sampled
    function automatic logic [31:0] m_mip();
        logic [31:0] v;
        v = 32'h0;
        if (t_hist[SYNC-1]) v = v | 32'h80;
        if (e_hist[SYNC-1]) v = v | 32'h800;
        return v;
    endfunction

    function automatic logic [31:0] m_read(input logic [11:0] a);
        case (a)
            12'h300: return m_mstatus;
            12'h304: return m_mie;
            12'h305: return m_mtvec;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'h344: return m_mip();
            default: return 32'h0;
        endcase
    endfunction

    // one clock of traffic: drive, check combinational outputs, advance the model
    task automatic cycle(input logic wr, input logic rd, input logic mr, input logic [1:0] op,
                         input logic [11:0] a, input logic [31:0] wd, input logic [31:0] pc);
        logic [31:0] rv, act, nv, tgt;
        logic        pend, take, old_mpie, old_mie;
        int          cause;
        @(negedge clk);
        csr_reg_wr = wr; csr_reg_rd = rd; is_mret = mr; csr_op = op;
        addr = a; wdata = wd; pc_in = pc; timer_irq = irq_t; ext_irq = irq_e;
        #1;
        rv    = m_read(a);
        act   = m_mie & m_mip();
        pend  = m_mstatus[3] && (act != 32'h0);
        take  = pend && !mr && !wr;
        cause = act[11] ? 11 : 7;
        tgt   = m_mtvec & 32'hFFFF_FFFC;
        if (m_mtvec[0]) tgt = tgt + 32'(4 * cause);
        if (mr && !take) tgt = m_mepc;
        obs_rdata = rdata; obs_taken = epc_taken; obs_epc = epc;
        chk("rdata", rdata, rd ? rv : 32'h0);
        chk("epc_taken", {31'b0, epc_taken}, {31'b0, (take || mr)});
        if (take || mr) chk("epc", epc, tgt);
        @(posedge clk);
        old_mpie = m_mstatus[7];
        old_mie  = m_mstatus[3];
        if (wr && op != 2'b00) begin
            nv = (op == 2'b01) ? wd : (op == 2'b10) ? (rv | wd) : (rv & ~wd);
            case (a)
                12'h300: m_mstatus = nv & 32'h88;
                12'h304: m_mie     = nv & 32'h880;
                12'h305: m_mtvec   = nv & 32'hFFFF_FFFD;
                12'h341: m_mepc    = nv & 32'hFFFF_FFFC;
                12'h342: m_mcause  = nv;
                default: ;
            endcase
        end
        if (take) begin
            m_mepc    = pc & 32'hFFFF_FFFC;
            m_mcause  = 32'h8000_0000 | 32'(cause);
            m_mstatus = old_mie ? 32'h80 : 32'h0;
        end
        if (mr) m_mstatus = 32'h80 | (old_mpie ? 32'h8 : 32'h0);
        t_hist.push_front(irq_t); void'(t_hist.pop_back());
        e_hist.push_front(irq_e); void'(e_hist.pop_back());
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 2'b00, 12'h000, 32'h0, 32'h0);
    endtask

    task automatic rd_csr(input logic [11:0] a);
        cycle(1'b0, 1'b1, 1'b0, 2'b00, a, 32'h0, 32'h0);
    endtask

    task automatic wr_csr(input logic [1:0] op, input logic [11:0] a, input logic [31:0] wd);
        cycle(1'b1, 1'b0, 1'b0, op, a, wd, 32'h0);
    endtask

    initial begin
        int          n;
        logic [11:0] alist[7];
        logic [31:0] bits[4];
        alist = '{12'h300, 12'h304, 12'h305, 12'h341, 12'h342, 12'h344, 12'h7C0};
        bits  = '{32'h8, 32'h80, 32'h880, 32'h88};

        reset = 1'b0; csr_reg_wr = 1'b0; csr_reg_rd = 1'b1; is_mret = 1'b1;
        csr_op = 2'b00; addr = 12'h305; wdata = 32'h0; pc_in = 32'h0;
        timer_irq = 1'b0; ext_irq = 1'b0;
        model_reset();
        #12;
        chk("reset_rdata", rdata, 32'h0);
        chk("reset_taken", {31'b0, epc_taken}, 32'h0);
        chk("reset_epc", epc, 32'h0);
        @(negedge clk);
        is_mret = 1'b0;
        reset = 1'b1;

        // mid-operation reset
        wr_csr(2'b01, 12'h305, 32'h100);
        rd_csr(12'h305);
        chk("mtvec_0x100", obs_rdata, 32'h100);
        @(negedge clk);
        csr_reg_wr = 1'b0; csr_reg_rd = 1'b1; is_mret = 1'b1; addr = 12'h305;
        #2 reset = 1'b0;
        #1;
        chk("midreset_rdata", rdata, 32'h0);
        chk("midreset_taken", {31'b0, epc_taken}, 32'h0);
        @(negedge clk);
        model_reset();
        is_mret = 1'b0;
        reset = 1'b1;
        rd_csr(12'h305);
        chk("mtvec_after_reset", obs_rdata, RST_MTVEC);

        // basic RW/RS/RC and unmapped addresses
        wr_csr(2'b01, 12'h304, 32'h880);
        wr_csr(2'b10, 12'h300, 32'h8);
        rd_csr(12'h304);
        chk("mie_0x880", obs_rdata, 32'h880);
        rd_csr(12'h300);
        chk("mstatus_set", obs_rdata, 32'h8);
        wr_csr(2'b11, 12'h300, 32'h8);
        rd_csr(12'h300);
        chk("mstatus_clr", obs_rdata, 32'h0);
        wr_csr(2'b01, 12'h344, 32'hFFFF_FFFF);
        rd_csr(12'h344);
        chk("mip_ro", obs_rdata, 32'h0);
        rd_csr(12'h7C0);
        chk("unmapped_rd", obs_rdata, 32'h0);

        // direct-mode timer interrupt and its latency through the synchronizer
        wr_csr(2'b01, 12'h305, 32'h200);
        wr_csr(2'b01, 12'h304, 32'h80);
        wr_csr(2'b10, 12'h300, 32'h8);
        irq_t = 1'b1;
        idle(1);
        n = 0;
        for (int i = 1; i <= 10 && n == 0; i++) begin
            cycle(1'b0, 1'b0, 1'b0, 2'b00, 12'h000, 32'h0, 32'h0000_1007);
            if (obs_taken) n = i;
        end
        chk("timer_latency", 32'(n), 32'(SYNC));
        chk("timer_epc", obs_epc, 32'h200);
        rd_csr(12'h341);
        chk("timer_mepc", obs_rdata, 32'h1004);
        rd_csr(12'h342);
        chk("timer_mcause", obs_rdata, 32'h8000_0007);
        rd_csr(12'h300);
        chk("timer_mstatus", obs_rdata, 32'h80);
        irq_t = 1'b0;
        idle(3);

        // vectored mode, external beats timer
        wr_csr(2'b01, 12'h305, 32'h201);
        wr_csr(2'b01, 12'h304, 32'h880);
        irq_t = 1'b1; irq_e = 1'b1;
        idle(3);
        wr_csr(2'b10, 12'h300, 32'h8);
        idle(1);
        chk("vec_taken", {31'b0, obs_taken}, 32'h1);
        chk("vec_epc", obs_epc, 32'h22C);
        rd_csr(12'h342);
        chk("vec_mcause", obs_rdata, 32'h8000_000B);

        // interrupt pending alongside a CSR write is deferred one cycle
        wr_csr(2'b10, 12'h300, 32'h8);
        cycle(1'b1, 1'b0, 1'b0, 2'b01, 12'h342, 32'h55, 32'h0000_3000);
        chk("defer_taken", {31'b0, obs_taken}, 32'h0);
        cycle(1'b0, 1'b0, 1'b0, 2'b00, 12'h000, 32'h0, 32'h0000_4006);
        chk("defer_retake", {31'b0, obs_taken}, 32'h1);
        rd_csr(12'h341);
        chk("defer_mepc", obs_rdata, 32'h4004);

        // mret with timer still high: re-taken immediately after MIE returns
        irq_t = 1'b0; irq_e = 1'b0;
        idle(3);
        wr_csr(2'b01, 12'h305, 32'h200);
        wr_csr(2'b01, 12'h341, 32'h1234);
        irq_t = 1'b1;
        idle(3);
        cycle(1'b0, 1'b0, 1'b1, 2'b00, 12'h000, 32'h0, 32'h0);
        chk("mret_taken", {31'b0, obs_taken}, 32'h1);
        chk("mret_epc", obs_epc, 32'h1234);
        cycle(1'b0, 1'b1, 1'b0, 2'b00, 12'h300, 32'h0, 32'h0000_5000);
        chk("mret_mstatus", obs_rdata, 32'h88);
        chk("mret_retake", {31'b0, obs_taken}, 32'h1);
        irq_t = 1'b0;
        idle(3);

        // randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            logic        wr, rd, mr;
            logic [11:0] a;
            logic [31:0] wd;
            if ($urandom_range(0, 7) == 0) irq_t = ~irq_t;
            if ($urandom_range(0, 7) == 0) irq_e = ~irq_e;
            wr = ($urandom_range(0, 2) == 0);
            rd = ($urandom_range(0, 1) == 0);
            mr = ($urandom_range(0, 11) == 0);
            a  = ($urandom_range(0, 9) == 0) ? 12'($urandom) : alist[$urandom_range(0, 6)];
            wd = ($urandom_range(0, 1) == 0) ? $urandom : bits[$urandom_range(0, 3)];
            cycle(wr, rd, mr, 2'($urandom_range(0, 3)), a, wd, $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
